// File: rtl/can_arb_field_rx.sv
// CAN receive front end: bus integration, SOF detection and arbitration-field capture.
// Optional macro CAN_EXT_ID_EN builds the 29-bit extended-identifier path (EXT_ID/RTR states).
module can_arb_field_rx #(
  parameter int IDLE_BITS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_bit,
  input  logic        sample_point,
  input  logic        stuff_bit,
  input  logic        rx_abort,
  output logic        bus_idle,
  output logic        sof,
  output logic        arbitration_active,
  output logic [28:0] id,
  output logic        ide,
  output logic        rtr,
  output logic        id_valid
);

  localparam int CW = $clog2(IDLE_BITS + 1);

  typedef enum logic [2:0] {
    ST_INTEGRATE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_BASE_ID   = 3'd2,
    ST_SRR_RTR   = 3'd3,
`ifdef CAN_EXT_ID_EN
    ST_IDE       = 3'd4,
    ST_EXT_ID    = 3'd5,
    ST_RTR       = 3'd6
`else
    ST_IDE       = 3'd4
`endif
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [4:0]    bits, bits_nx;
  logic [10:0]   base, base_nx;
  logic          r12, r12_nx;
  logic          sof_nx, valid_nx, field_nx;
  logic [28:0]   id_nx;
  logic          ide_nx, rtr_nx;
  logic          field_smp;
`ifdef CAN_EXT_ID_EN
  logic [17:0]   ext, ext_nx;
`endif

  // Next-state and field-capture logic; registered outputs are derived from the *_nx values.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    bits_nx   = bits;
    base_nx   = base;
    r12_nx    = r12;
    sof_nx    = 1'b0;
    valid_nx  = 1'b0;
    id_nx     = id;
    ide_nx    = ide;
    rtr_nx    = rtr;
`ifdef CAN_EXT_ID_EN
    ext_nx    = ext;
`endif
    field_smp = sample_point && !stuff_bit;

    if (rx_abort) begin
      state_nx = ST_INTEGRATE;
      cnt_nx   = '0;
      bits_nx  = 5'd0;
    end else begin
      case (state)
        ST_INTEGRATE: begin
          if (sample_point) begin
            if (!rx_bit) begin
              cnt_nx = '0;
            end else if (cnt == CW'(IDLE_BITS - 1)) begin
              state_nx = ST_IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end else begin
            cnt_nx = cnt;
          end
        end
        ST_IDLE: begin
          if (sample_point && !rx_bit) begin
            state_nx = ST_BASE_ID;
            bits_nx  = 5'd0;
            sof_nx   = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_BASE_ID: begin
          if (field_smp) begin
            base_nx = {base[9:0], rx_bit};
            if (bits == 5'd10) begin
              state_nx = ST_SRR_RTR;
              bits_nx  = 5'd0;
            end else begin
              bits_nx = bits + 5'd1;
            end
          end else begin
            bits_nx = bits;
          end
        end
        ST_SRR_RTR: begin
          if (field_smp) begin
            r12_nx   = rx_bit;
            state_nx = ST_IDE;
          end else begin
            r12_nx = r12;
          end
        end
        ST_IDE: begin
          if (field_smp && !rx_bit) begin
            id_nx    = {18'd0, base};
            ide_nx   = 1'b0;
            rtr_nx   = r12;
            valid_nx = 1'b1;
            state_nx = ST_INTEGRATE;
            cnt_nx   = '0;
          end else if (field_smp) begin
`ifdef CAN_EXT_ID_EN
            state_nx = ST_EXT_ID;
            bits_nx  = 5'd0;
`else
            // Extended frames are not decoded here; hand the rest of the frame to integration.
            state_nx = ST_INTEGRATE;
            cnt_nx   = '0;
`endif
          end else begin
            state_nx = ST_IDE;
          end
        end
`ifdef CAN_EXT_ID_EN
        ST_EXT_ID: begin
          if (field_smp) begin
            ext_nx = {ext[16:0], rx_bit};
            if (bits == 5'd17) begin
              state_nx = ST_RTR;
              bits_nx  = 5'd0;
            end else begin
              bits_nx = bits + 5'd1;
            end
          end else begin
            bits_nx = bits;
          end
        end
        ST_RTR: begin
          if (field_smp) begin
            id_nx    = {base, ext};
            ide_nx   = 1'b1;
            rtr_nx   = rx_bit;
            valid_nx = 1'b1;
            state_nx = ST_INTEGRATE;
            cnt_nx   = '0;
          end else begin
            state_nx = ST_RTR;
          end
        end
`endif
        default: begin
          state_nx = ST_INTEGRATE;
          cnt_nx   = '0;
        end
      endcase
    end

    field_nx = (state_nx != ST_INTEGRATE) && (state_nx != ST_IDLE);
  end

  // State, capture registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_INTEGRATE;
      cnt                <= '0;
      bits               <= 5'd0;
      base               <= 11'd0;
      r12                <= 1'b0;
`ifdef CAN_EXT_ID_EN
      ext                <= 18'd0;
`endif
      bus_idle           <= 1'b0;
      sof                <= 1'b0;
      arbitration_active <= 1'b0;
      id                 <= 29'd0;
      ide                <= 1'b0;
      rtr                <= 1'b0;
      id_valid           <= 1'b0;
    end else begin
      state              <= state_nx;
      cnt                <= cnt_nx;
      bits               <= bits_nx;
      base               <= base_nx;
      r12                <= r12_nx;
`ifdef CAN_EXT_ID_EN
      ext                <= ext_nx;
`endif
      bus_idle           <= (state_nx == ST_IDLE);
      sof                <= sof_nx;
      arbitration_active <= field_nx;
      id                 <= id_nx;
      ide                <= ide_nx;
      rtr                <= rtr_nx;
      id_valid           <= valid_nx;
    end
  end

endmodule
